// File: rtl/n1_seq_ctrl_if.sv
// n1 sequencer memory bus: program RAM read port and data RAM port.
// master = sequencer side, slave = RAM side.
interface n1_seq_ctrl_if #(
   parameter int PC_W = 5,
   parameter int DA_W = 5
);
   logic            pram_req;
   logic [PC_W-1:0] pram_addr;
   logic [15:0]     pram_rdata;
   logic            pram_rvalid;
   logic            dram_req;
   logic            dram_we;
   logic [DA_W-1:0] dram_addr;
   logic [7:0]      dram_wdata;
   logic [7:0]      dram_rdata;
   logic            dram_ack;

   modport master (
      output pram_req, pram_addr,
      input  pram_rdata, pram_rvalid,
      output dram_req, dram_we, dram_addr, dram_wdata,
      input  dram_rdata, dram_ack
   );

   modport slave (
      input  pram_req, pram_addr,
      output pram_rdata, pram_rvalid,
      input  dram_req, dram_we, dram_addr, dram_wdata,
      output dram_rdata, dram_ack
   );
endinterface

// File: rtl/n1_seq_ctrl.sv
// n1 fetch/execute sequencer: pc, ir, accumulator, carry, error.
// Drives single-cycle request strobes to program and data RAM.
module n1_seq_ctrl #(
   parameter int PC_W = 5,
   parameter int DA_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   n1_seq_ctrl_if.master   mem,
   output logic [PC_W-1:0] pc,
   output logic [7:0]      acc,
   output logic            carry,
   output logic            halted,
   output logic            err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_FWAIT,
      S_EXEC,
      S_MWAIT,
      S_HALT
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_LD   = 4'h2;
   localparam logic [3:0] OP_ST   = 4'h3;
   localparam logic [3:0] OP_ADD  = 4'h4;
   localparam logic [3:0] OP_SUB  = 4'h5;
   localparam logic [3:0] OP_JMP  = 4'h6;
   localparam logic [3:0] OP_JZ   = 4'h7;
   localparam logic [3:0] OP_HALT = 4'hF;

   state_t          state, state_n;
   logic [PC_W-1:0] pc_n;
   logic [7:0]      acc_n;
   logic [15:0]     ir, ir_n;
   logic            carry_n;
   logic            err_n;

   logic [3:0]      op;
   logic [PC_W-1:0] tgt;
   logic [PC_W-1:0] pc_inc;
   logic [8:0]      sum;
   logic [8:0]      diff;
   logic            unused_ir;

   assign op        = ir[15:12];
   assign tgt       = PC_W'(ir[4:0]);
   assign pc_inc    = pc + PC_W'(1);
   assign sum       = {1'b0, acc} + {1'b0, mem.dram_rdata};
   assign diff      = {1'b0, acc} - {1'b0, mem.dram_rdata};
   assign unused_ir = ^ir[11:8];

   // Next-state, register updates and memory strobes from state/ir.
   always_comb begin
      state_n        = state;
      pc_n           = pc;
      acc_n          = acc;
      ir_n           = ir;
      carry_n        = carry;
      err_n          = err;
      mem.pram_req   = 1'b0;
      mem.pram_addr  = pc;
      mem.dram_req   = 1'b0;
      mem.dram_we    = 1'b0;
      mem.dram_addr  = DA_W'(ir[4:0]);
      mem.dram_wdata = acc;

      unique case (state)
         S_IDLE: begin
            if (start) begin
               pc_n    = '0;
               state_n = S_FETCH;
            end
         end
         S_FETCH: begin
            mem.pram_req = 1'b1;
            state_n      = S_FWAIT;
         end
         S_FWAIT: begin
            if (mem.pram_rvalid) begin
               ir_n    = mem.pram_rdata;
               state_n = S_EXEC;
            end
         end
         S_EXEC: begin
            unique case (op)
               OP_NOP: begin
                  pc_n    = pc_inc;
                  state_n = S_FETCH;
               end
               OP_LDI: begin
                  acc_n   = ir[7:0];
                  pc_n    = pc_inc;
                  state_n = S_FETCH;
               end
               OP_LD, OP_ST, OP_ADD, OP_SUB: begin
                  mem.dram_req = 1'b1;
                  mem.dram_we  = (op == OP_ST);
                  state_n      = S_MWAIT;
               end
               OP_JMP: begin
                  pc_n    = tgt;
                  state_n = S_FETCH;
               end
               OP_JZ: begin
                  pc_n    = (acc == 8'h00) ? tgt : pc_inc;
                  state_n = S_FETCH;
               end
               OP_HALT: begin
                  state_n = S_HALT;
               end
               default: begin
                  err_n   = 1'b1;
                  state_n = S_HALT;
               end
            endcase
         end
         S_MWAIT: begin
            if (mem.dram_ack) begin
               unique case (op)
                  OP_LD: acc_n = mem.dram_rdata;
                  OP_ADD: {carry_n, acc_n} = sum;
                  OP_SUB: {carry_n, acc_n} = diff;
                  default: ;
               endcase
               pc_n    = pc_inc;
               state_n = S_FETCH;
            end
         end
         S_HALT: begin
            if (start) begin
               pc_n    = '0;
               err_n   = 1'b0;
               carry_n = 1'b0;
               state_n = S_FETCH;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // State and architectural registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         pc     <= '0;
         acc    <= '0;
         ir     <= '0;
         carry  <= 1'b0;
         err    <= 1'b0;
         halted <= 1'b0;
      end else begin
         state  <= state_n;
         pc     <= pc_n;
         acc    <= acc_n;
         ir     <= ir_n;
         carry  <= carry_n;
         err    <= err_n;
         halted <= (state_n == S_HALT);
      end
   end

endmodule

// File: tb/tb_n1_seq_ctrl.sv
// Self-checking bench for n1_seq_ctrl with behavioural program/data RAMs.
// Directed vector table plus hand-written multi-cycle sequences.
module tb_n1_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [4:0] pc;
   logic [7:0] acc;
   logic       carry;
   logic       halted;
   logic       err;

   n1_seq_ctrl_if #(.PC_W(5), .DA_W(5)) bus ();

   n1_seq_ctrl #(.PC_W(5), .DA_W(5)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .mem    (bus),
      .pc     (pc),
      .acc    (acc),
      .carry  (carry),
      .halted (halted),
      .err    (err)
   );

   always #5 clk = ~clk;

   logic [15:0] pram [32];
   logic [7:0]  dram [32];

   int p_lat = 1;
   int d_lat = 1;
   bit spur_en = 0;
   bit spur_next = 0;
   int p_cnt = 0;
   int d_cnt = 0;
   logic [4:0] p_addr;
   logic [4:0] d_addr;
   logic       d_we;
   logic [7:0] d_wdata;

   typedef struct {
      int         cyc;
      logic [4:0] addr;
   } fetch_t;

   fetch_t fq[$];
   int cyc = 0;
   int n_preq = 0;
   int n_dreq = 0;

   int checks = 0;
   int errors = 0;

   initial begin
      bus.pram_rvalid = 1'b0;
      bus.pram_rdata  = 16'h0;
      bus.dram_ack    = 1'b0;
      bus.dram_rdata  = 8'h0;
   end

   // RAM responders and request monitor, all on the falling edge.
   always @(negedge clk) begin
      cyc++;
      bus.pram_rvalid = 1'b0;
      bus.dram_ack    = 1'b0;
      if (spur_next) begin
         bus.pram_rvalid = 1'b1;
         bus.pram_rdata  = 16'h1055;
         bus.dram_ack    = 1'b1;
         bus.dram_rdata  = 8'h77;
         spur_next       = 0;
      end
      if (p_cnt > 0) begin
         p_cnt--;
         if (p_cnt == 0) begin
            bus.pram_rvalid = 1'b1;
            bus.pram_rdata  = pram[p_addr];
            if (spur_en) spur_next = 1;
         end
      end
      if (d_cnt > 0) begin
         d_cnt--;
         if (d_cnt == 0) begin
            bus.dram_ack = 1'b1;
            if (d_we) dram[d_addr] = d_wdata;
            else bus.dram_rdata = dram[d_addr];
         end
      end
      if (bus.pram_req) begin
         p_cnt  = p_lat;
         p_addr = bus.pram_addr;
         n_preq++;
         fq.push_back('{cyc, bus.pram_addr});
      end
      if (bus.dram_req) begin
         d_cnt   = d_lat;
         d_addr  = bus.dram_addr;
         d_we    = bus.dram_we;
         d_wdata = bus.dram_wdata;
         n_dreq++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_halt(input string name);
      int i;
      for (i = 0; i < 400; i++) begin
         @(negedge clk);
         if (halted) break;
      end
      if (i == 400) begin
         checks++;
         errors++;
         $display("FAIL %s: halt timeout got running expected halted", name);
      end
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 32; i++) pram[i] = 16'hF000;
   endtask

   typedef struct {
      logic [7:0]  acc0;
      logic [15:0] ins;
      logic [7:0]  mem;
      logic [7:0]  e_acc;
      logic        e_c;
      logic [4:0]  e_pc;
      logic [7:0]  e_mem;
   } vec_t;

   vec_t tv[12];

   initial begin
      int b;
      int pr0;
      int dr0;

      tv[0]  = '{8'hFF, 16'h4005, 8'h01, 8'h00, 1'b1, 5'd2,  8'h01};
      tv[1]  = '{8'h00, 16'h5006, 8'h01, 8'hFF, 1'b1, 5'd2,  8'h01};
      tv[2]  = '{8'h00, 16'h7007, 8'h00, 8'h00, 1'b0, 5'd7,  8'h00};
      tv[3]  = '{8'h03, 16'h7007, 8'h00, 8'h03, 1'b0, 5'd2,  8'h00};
      tv[4]  = '{8'h11, 16'h2008, 8'hA5, 8'hA5, 1'b0, 5'd2,  8'hA5};
      tv[5]  = '{8'h5C, 16'h3009, 8'h00, 8'h5C, 1'b0, 5'd2,  8'h5C};
      tv[6]  = '{8'h10, 16'h400A, 8'h20, 8'h30, 1'b0, 5'd2,  8'h20};
      tv[7]  = '{8'h30, 16'h500B, 8'h10, 8'h20, 1'b0, 5'd2,  8'h10};
      tv[8]  = '{8'h01, 16'h600C, 8'h00, 8'h01, 1'b0, 5'd12, 8'h00};
      tv[9]  = '{8'h00, 16'h1FE7, 8'h00, 8'hE7, 1'b0, 5'd2,  8'h00};
      tv[10] = '{8'h77, 16'h0000, 8'h00, 8'h77, 1'b0, 5'd2,  8'h00};
      tv[11] = '{8'h44, 16'h500D, 8'h44, 8'h00, 1'b0, 5'd2,  8'h44};

      for (int i = 0; i < 32; i++) dram[i] = 8'h00;
      clear_prog();

      // reset and idle
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_pc", 32'(pc), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_preq", 32'(bus.pram_req), 0);
      rst = 1'b0;
      pr0 = n_preq;
      repeat (10) @(negedge clk);
      chk("idle_pc", 32'(pc), 0);
      chk("idle_acc", 32'(acc), 0);
      chk("idle_preq", 32'(n_preq - pr0), 0);
      chk("idle_halted", 32'(halted), 0);
      chk("idle_err", 32'(err), 0);

      // straight-line program, zero-wait
      clear_prog();
      pram[0] = 16'h1005;
      pram[1] = 16'h3003;
      pram[2] = 16'h4003;
      pram[3] = 16'hF000;
      dram[3] = 8'h00;
      fq.delete();
      pulse_start();
      wait_halt("sl0");
      chk("sl0_mem3", 32'(dram[3]), 32'h05);
      chk("sl0_acc", 32'(acc), 32'h0A);
      chk("sl0_carry", 32'(carry), 0);
      chk("sl0_pc", 32'(pc), 3);
      chk("sl0_halted", 32'(halted), 1);
      chk("sl0_nfetch", 32'(fq.size()), 4);
      if (fq.size() == 4) begin
         chk("sl0_cyc_ldi", 32'(fq[1].cyc - fq[0].cyc), 3);
         chk("sl0_cyc_st", 32'(fq[2].cyc - fq[1].cyc), 4);
         chk("sl0_cyc_add", 32'(fq[3].cyc - fq[2].cyc), 4);
      end

      // same program with wait states and spurious strobes
      p_lat = 4;
      d_lat = 3;
      spur_en = 1;
      dram[3] = 8'h00;
      fq.delete();
      pr0 = n_preq;
      dr0 = n_dreq;
      pulse_start();
      wait_halt("slw");
      chk("slw_mem3", 32'(dram[3]), 32'h05);
      chk("slw_acc", 32'(acc), 32'h0A);
      chk("slw_carry", 32'(carry), 0);
      chk("slw_pc", 32'(pc), 3);
      chk("slw_npreq", 32'(n_preq - pr0), 4);
      chk("slw_ndreq", 32'(n_dreq - dr0), 2);
      if (fq.size() == 4) begin
         chk("slw_cyc_ldi", 32'(fq[1].cyc - fq[0].cyc), 6);
         chk("slw_cyc_add", 32'(fq[3].cyc - fq[2].cyc), 9);
      end

      // vector table, zero-wait then with waits
      for (int pass = 0; pass < 2; pass++) begin
         p_lat   = (pass == 0) ? 1 : 4;
         d_lat   = (pass == 0) ? 1 : 3;
         spur_en = (pass != 0);
         for (int v = 0; v < 12; v++) begin
            clear_prog();
            pram[0] = {8'h10, tv[v].acc0};
            pram[1] = tv[v].ins;
            b = int'(tv[v].ins[4:0]);
            dram[b] = tv[v].mem;
            pulse_start();
            wait_halt($sformatf("v%0d_%0d", pass, v));
            chk($sformatf("v%0d_%0d_acc", pass, v), 32'(acc),
                32'(tv[v].e_acc));
            chk($sformatf("v%0d_%0d_carry", pass, v), 32'(carry),
                32'(tv[v].e_c));
            chk($sformatf("v%0d_%0d_pc", pass, v), 32'(pc),
                32'(tv[v].e_pc));
            chk($sformatf("v%0d_%0d_mem", pass, v), 32'(dram[b]),
                32'(tv[v].e_mem));
            chk($sformatf("v%0d_%0d_err", pass, v), 32'(err), 0);
         end
      end
      p_lat = 1;
      d_lat = 1;
      spur_en = 0;

      // pc wrap: JMP 31, NOP at 31, next fetch at 0
      clear_prog();
      pram[0]  = 16'h601F;
      pram[31] = 16'h0000;
      fq.delete();
      pulse_start();
      for (int i = 0; i < 100 && fq.size() < 3; i++) @(negedge clk);
      chk("wrap_nfetch", 32'(fq.size() >= 3), 1);
      if (fq.size() >= 3) begin
         chk("wrap_a0", 32'(fq[0].addr), 0);
         chk("wrap_a1", 32'(fq[1].addr), 31);
         chk("wrap_a2", 32'(fq[2].addr), 0);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      // illegal opcode
      clear_prog();
      pram[0] = 16'h1042;
      pram[1] = 16'h9000;
      pulse_start();
      wait_halt("ill");
      chk("ill_err", 32'(err), 1);
      chk("ill_halted", 32'(halted), 1);
      chk("ill_pc", 32'(pc), 1);
      chk("ill_acc", 32'(acc), 32'h42);
      fq.delete();
      pulse_start();
      chk("ill_restart_err", 32'(err), 0);
      chk("ill_restart_halted", 32'(halted), 0);
      wait_halt("ill2");
      chk("ill_restart_addr", 32'(fq.size() > 0 ? fq[0].addr : 5'd31), 0);
      chk("ill2_err", 32'(err), 1);

      // reset while an ADD waits for its ack
      d_lat = 3;
      clear_prog();
      pram[0] = 16'h1033;
      pram[1] = 16'h4004;
      dram[4] = 8'h01;
      pulse_start();
      begin
         int i;
         for (i = 0; i < 50; i++) begin
            if (bus.dram_req) break;
            @(negedge clk);
         end
         if (i == 50) begin
            checks++;
            errors++;
            $display("FAIL rmid_dreq: timeout got none expected dram_req");
         end
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rmid_pc", 32'(pc), 0);
      chk("rmid_acc", 32'(acc), 0);
      chk("rmid_dreq", 32'(bus.dram_req), 0);
      chk("rmid_halted", 32'(halted), 0);
      rst = 1'b0;
      pr0 = n_preq;
      repeat (5) @(negedge clk);
      chk("late_acc", 32'(acc), 0);
      chk("late_pc", 32'(pc), 0);
      chk("late_carry", 32'(carry), 0);
      chk("late_preq", 32'(n_preq - pr0), 0);
      pulse_start();
      wait_halt("rst_restart");
      chk("rr_acc", 32'(acc), 32'h34);
      chk("rr_pc", 32'(pc), 2);
      chk("rr_carry", 32'(carry), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
